// File: rtl/icache_pkg.sv
// Shared types and helpers for the n-way instruction cache: FSM states,
// address-field width helpers and the cache-line entry layout.
package icache_pkg;

    // Widest tag and line an entry can hold; a cache instance uses the low
    // bits only. 64 tag bits cover any physical address up to 64 bits and
    // 256 line bits cover bundles of up to 8 functional units.
    localparam int TAG_MAX_W  = 64;
    localparam int LINE_MAX_W = 256;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        RESPOND
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [TAG_MAX_W-1:0]  tag;
        logic [LINE_MAX_W-1:0] data;
    } line_entry_t;

    // Byte offset inside a line of nfu 32-bit words.
    function automatic int offset_bits(input int nfu);
        return $clog2(nfu * 4);
    endfunction

    function automatic int index_bits(input int nsets);
        return $clog2(nsets);
    endfunction

    function automatic int tag_bits(input int pal, input int nfu, input int nsets);
        return pal - offset_bits(nfu) - index_bits(nsets);
    endfunction

    // A direct-mapped cache still gets a one-bit way number.
    function automatic int way_bits(input int nways);
        return (nways > 1) ? $clog2(nways) : 1;
    endfunction

endpackage

// File: rtl/icache_nway_if.sv
// Fetch and refill bus of the instruction cache. "slave" is the cache side,
// "master" is the environment (fetch unit plus refill memory).
interface icache_nway_if #(
    parameter int NFU                     = 2,
    parameter int PHYSICAL_ADDRESS_LENGTH = 56
);
    logic                               req_valid;
    logic                               req_ready;
    logic [PHYSICAL_ADDRESS_LENGTH-1:0] address;
    logic                               resp_valid;
    logic [NFU*32-1:0]                  data;
    logic                               misaligned;
    logic                               invalidate;
    logic                               mem_req_valid;
    logic                               mem_req_ready;
    logic [PHYSICAL_ADDRESS_LENGTH-1:0] mem_addr;
    logic                               mem_resp_valid;
    logic [NFU*32-1:0]                  mem_resp_data;

    modport slave (
        input  req_valid, address, invalidate,
        output req_ready, resp_valid, data, misaligned,
        output mem_req_valid, mem_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output req_valid, address, invalidate,
        input  req_ready, resp_valid, data, misaligned,
        input  mem_req_valid, mem_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/icache_tag_compare.sv
// Parallel tag match across all ways of one set, with hit-way encode.
// At most one valid way should ever match; the lowest index wins if not.
module icache_tag_compare
    import icache_pkg::*;
#(
    parameter int NWAYS = 2,
    parameter int WAY_W = way_bits(NWAYS)
) (
    input  logic [NWAYS-1:0][TAG_MAX_W-1:0] way_tags,
    input  logic [NWAYS-1:0]                way_valid,
    input  logic [TAG_MAX_W-1:0]            lookup_tag,
    output logic                            hit,
    output logic [WAY_W-1:0]                hit_way
);

    // Compare every way at once; scan downwards so the lowest match sticks.
    always_comb begin
        // NOTE: defaults before the loop keep every path assigned, so no latch.
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (way_valid[w] && (way_tags[w] == lookup_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with single-line refill.
// Address = TAG | INDEX | OFFSET; requests with a non-zero offset are
// answered with misaligned=1 and never touch the tags or memory.
// Optional: define ICACHE_PERF_COUNTERS_EN to add hit_count / miss_count.
module icache_nway
    import icache_pkg::*;
#(
    parameter int NFU                     = 2,
    parameter int NSETS                   = 64,
    parameter int NWAYS                   = 2,
    parameter int PHYSICAL_ADDRESS_LENGTH = 56
) (
    input  logic         clk,
    input  logic         rst,
    icache_nway_if.slave bus
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int PAL    = PHYSICAL_ADDRESS_LENGTH;
    localparam int LINE_W = NFU * 32;
    localparam int OFF_W  = offset_bits(NFU);
    localparam int IDX_W  = index_bits(NSETS);
    localparam int TAG_W  = tag_bits(PAL, NFU, NSETS);
    localparam int WAY_W  = way_bits(NWAYS);

    state_t            state_q;
    logic [PAL-1:0]    addr_q;
    logic              inv_pending_q;
    line_entry_t       lines_q [NWAYS][NSETS];
    logic [WAY_W-1:0]  rr_q    [NSETS];

    logic [IDX_W-1:0]                idx;
    logic [TAG_MAX_W-1:0]            lookup_tag;
    logic                            addr_misaligned;
    logic [NWAYS-1:0][TAG_MAX_W-1:0] set_tags;
    logic [NWAYS-1:0]                set_valid;
    logic                            hit;
    logic [WAY_W-1:0]                hit_way;
    logic [LINE_W-1:0]               hit_data;
    logic [WAY_W-1:0]                victim;
    logic                            victim_found;
    logic [WAY_W-1:0]                rr_next;

    assign idx             = addr_q[OFF_W +: IDX_W];
    assign lookup_tag      = TAG_MAX_W'(addr_q[PAL-1 -: TAG_W]);
    assign addr_misaligned = |addr_q[OFF_W-1:0];
    assign hit_data        = lines_q[hit_way][idx].data[LINE_W-1:0];
    assign rr_next         = (rr_q[idx] == WAY_W'(NWAYS - 1)) ? '0 : rr_q[idx] + WAY_W'(1);

    // Only an idle cache with no flush waiting may take a new request.
    assign bus.req_ready = (state_q == IDLE) && !bus.invalidate && !inv_pending_q && !rst;

    // Gather the tags and valid bits of the addressed set for the comparator.
    always_comb begin
        set_tags  = '0;
        set_valid = '0;
        for (int w = 0; w < NWAYS; w++) begin
            set_tags[w]  = lines_q[w][idx].tag;
            set_valid[w] = lines_q[w][idx].valid;
        end
    end

    // Victim: lowest-index invalid way, otherwise the set's round-robin way.
    always_comb begin
        victim       = rr_q[idx];
        victim_found = 1'b0;
        for (int w = 0; w < NWAYS; w++) begin
            if (!victim_found && !set_valid[w]) begin
                victim       = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
    end

    icache_tag_compare #(
        .NWAYS (NWAYS),
        .WAY_W (WAY_W)
    ) u_tag_compare (
        .way_tags   (set_tags),
        .way_valid  (set_valid),
        .lookup_tag (lookup_tag),
        .hit        (hit),
        .hit_way    (hit_way)
    );

    // Control FSM, registered outputs, valid bits, line fills and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking everywhere, so every branch reads pre-edge state.
            state_q           <= IDLE;
            addr_q            <= '0;
            inv_pending_q     <= 1'b0;
            bus.resp_valid    <= 1'b0;
            bus.data          <= '0;
            bus.misaligned    <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_addr      <= '0;
            for (int s = 0; s < NSETS; s++) begin
                rr_q[s] <= '0;
            end
            // NOTE: only valid bits are reset; tag/data stay unreset so they can map to RAM.
            for (int w = 0; w < NWAYS; w++) begin
                for (int s = 0; s < NSETS; s++) begin
                    lines_q[w][s].valid <= 1'b0;
                end
            end
`ifdef ICACHE_PERF_COUNTERS_EN
            hit_count  <= '0;
            miss_count <= '0;
`endif
        end else begin
            bus.resp_valid <= 1'b0;

            // A flush seen while busy waits for the next IDLE cycle.
            if ((state_q != IDLE) && bus.invalidate) begin
                inv_pending_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.invalidate || inv_pending_q) begin
                        inv_pending_q <= 1'b0;
                        for (int w = 0; w < NWAYS; w++) begin
                            for (int s = 0; s < NSETS; s++) begin
                                lines_q[w][s].valid <= 1'b0;
                            end
                        end
                    end else if (bus.req_valid) begin
                        addr_q  <= bus.address;
                        state_q <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (addr_misaligned) begin
                        bus.misaligned <= 1'b1;
                        bus.data       <= '0;
                        bus.resp_valid <= 1'b1;
                        state_q        <= RESPOND;
                    end else if (hit) begin
                        bus.misaligned <= 1'b0;
                        bus.data       <= hit_data;
                        bus.resp_valid <= 1'b1;
                        state_q        <= RESPOND;
`ifdef ICACHE_PERF_COUNTERS_EN
                        hit_count <= hit_count + 32'd1;
`endif
                    end else begin
                        bus.mem_req_valid <= 1'b1;
                        bus.mem_addr      <= {addr_q[PAL-1:OFF_W], {OFF_W{1'b0}}};
                        state_q           <= MISS_REQ;
`ifdef ICACHE_PERF_COUNTERS_EN
                        miss_count <= miss_count + 32'd1;
`endif
                    end
                end

                MISS_REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state_q           <= MISS_WAIT;
                    end
                end

                MISS_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        lines_q[victim][idx].valid <= 1'b1;
                        lines_q[victim][idx].tag   <= lookup_tag;
                        lines_q[victim][idx].data  <= LINE_MAX_W'(bus.mem_resp_data);
                        rr_q[idx]                  <= rr_next;
                        bus.misaligned             <= 1'b0;
                        bus.data                   <= bus.mem_resp_data;
                        bus.resp_valid             <= 1'b1;
                        state_q                    <= RESPOND;
                    end
                end

                RESPOND: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (NFU=2, NSETS=64, NWAYS=2). Expected
// responses are queued when a fetch is issued and popped on resp_valid.
// Define ICACHE_PERF_COUNTERS_EN to also check the performance counters.
module tb_icache_nway;

    localparam int NFU   = 2;
    localparam int NSETS = 64;
    localparam int NWAYS = 2;
    localparam int PAL   = 56;

    logic clk = 1'b0;
    logic rst = 1'b1;

    icache_nway_if #(.NFU(NFU), .PHYSICAL_ADDRESS_LENGTH(PAL)) bus ();

`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_nway #(
        .NFU                     (NFU),
        .NSETS                   (NSETS),
        .NWAYS                   (NWAYS),
        .PHYSICAL_ADDRESS_LENGTH (PAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ICACHE_PERF_COUNTERS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid      = 1'b0;
        bus.address        = '0;
        bus.invalidate     = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready",     64'(bus.req_ready),     64'd0);
        check("rst_resp_valid",    64'(bus.resp_valid),    64'd0);
        check("rst_misaligned",    64'(bus.misaligned),    64'd0);
        check("rst_data",          bus.data,               64'd0);
        check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst_mem_addr",      64'(bus.mem_addr),      64'd0);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // One fetch, with a small refill memory that answers with 'line' and
    // holds off mem_req_ready for two cycles to exercise the MISS_REQ hold.
    task automatic fetch(input logic [55:0] a, input bit exp_miss,
                         input logic [63:0] line, input string name);
        exp_t        e;
        logic [55:0] exp_maddr;
        int          k;
        int          hold;
        bit          got;
        bit          mem_seen;
        bit          sent;
        e.mis     = (a[2:0] != 3'd0);
        e.data    = e.mis ? 64'd0 : line;
        exp_maddr = {a[55:3], 3'b000};
        exp_q.push_back(e);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.address   = a;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_accept"}, 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.address   = 56'({$urandom(), $urandom()});

        k        = 1;
        hold     = 2;
        got      = 1'b0;
        mem_seen = 1'b0;
        sent     = 1'b0;
        while (!got && k < 40) begin
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            if (bus.resp_valid) begin
                got = 1'b1;
                check({name, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check({name, "_data"},       bus.data,             e.data);
                    check({name, "_misaligned"}, 64'(bus.misaligned),  64'(e.mis));
                    if (!exp_miss) begin
                        check({name, "_latency"}, 64'(k), 64'd2);
                    end
                end
            end else begin
                if (bus.mem_req_valid) begin
                    mem_seen = 1'b1;
                    check({name, "_mem_addr"}, 64'(bus.mem_addr), 64'(exp_maddr));
                    if (hold == 0) bus.mem_req_ready = 1'b1;
                    else           hold--;
                end else if (mem_seen && !sent) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = line;
                    sent = 1'b1;
                end
                @(negedge clk);
                k++;
            end
        end
        check({name, "_resp_seen"}, 64'(got),      64'd1);
        check({name, "_mem_used"},  64'(mem_seen), 64'(exp_miss));

        @(negedge clk);
        check({name, "_pulse_end"},  64'(bus.resp_valid), 64'd0);
        check({name, "_data_hold"},  bus.data,            e.data);
        check({name, "_mis_hold"},   64'(bus.misaligned), 64'(e.mis));
    endtask

    // Runaway guard.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        idle_inputs();

        // Basic miss, repeated hits, second set, misaligned request.
        do_reset();
        fetch(56'h1000, 1'b1, 64'hDEADBEEF_CAFEF00D, "fill_1000");
        fetch(56'h1000, 1'b0, 64'hDEADBEEF_CAFEF00D, "hit_1000_a");
        fetch(56'h1000, 1'b0, 64'hDEADBEEF_CAFEF00D, "hit_1000_b");
        fetch(56'h1000, 1'b0, 64'hDEADBEEF_CAFEF00D, "hit_1000_c");
`ifdef ICACHE_PERF_COUNTERS_EN
        check("perf_miss_count", 64'(miss_count), 64'd1);
        check("perf_hit_count",  64'(hit_count),  64'd3);
`endif
        fetch(56'h1008, 1'b1, 64'h1111_2222_3333_4444, "fill_1008");
        fetch(56'h1008, 1'b0, 64'h1111_2222_3333_4444, "hit_1008");
        fetch(56'h1004, 1'b0, 64'h0,                   "misaligned_1004");
        fetch(56'h1000, 1'b0, 64'hDEADBEEF_CAFEF00D,   "hit_1000_after_mis");

        // Three fills of set 0: the third evicts way 0 (0x0000).
        do_reset();
        fetch(56'h0000, 1'b1, 64'hAAAA_0000_AAAA_0000, "fill_0000");
        fetch(56'h0200, 1'b1, 64'hBBBB_0200_BBBB_0200, "fill_0200");
        fetch(56'h0400, 1'b1, 64'hCCCC_0400_CCCC_0400, "fill_0400");
        fetch(56'h0200, 1'b0, 64'hBBBB_0200_BBBB_0200, "hit_0200");
        fetch(56'h0400, 1'b0, 64'hCCCC_0400_CCCC_0400, "hit_0400");
        fetch(56'h0000, 1'b1, 64'hDDDD_0000_DDDD_0000, "refill_0000");

        // Invalidate in IDLE, with a simultaneous request that must wait.
        do_reset();
        fetch(56'h1000, 1'b1, 64'h0123_4567_89AB_CDEF, "inv_fill_1000");
        fetch(56'h1000, 1'b0, 64'h0123_4567_89AB_CDEF, "inv_hit_1000");
        @(negedge clk);
        bus.invalidate = 1'b1;
        bus.req_valid  = 1'b1;
        bus.address    = 56'h1000;
        #1;
        check("inv_blocks_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        bus.invalidate = 1'b0;
        bus.req_valid  = 1'b0;
        #1;
        check("inv_back_to_ready", 64'(bus.req_ready), 64'd1);
        fetch(56'h1000, 1'b1, 64'hFEDC_BA98_7654_3210, "inv_refill_1000");

        // Reset during MISS_WAIT abandons the refill.
        do_reset();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.address   = 56'h2000;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 0;
        while (!bus.mem_req_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("abort_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        check("abort_mem_addr",      64'(bus.mem_addr),      64'h2000);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_req_after_rst", 64'(bus.mem_req_valid), 64'd0);
        check("abort_resp_after_rst",    64'(bus.resp_valid),    64'd0);
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h0BAD_0BAD_0BAD_0BAD;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        check("abort_stray_resp_ignored", 64'(bus.resp_valid), 64'd0);
        check("abort_idle_ready",         64'(bus.req_ready),  64'd1);
        fetch(56'h2000, 1'b1, 64'h2000_2000_5555_6666, "abort_refetch_2000");

        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
